// File: rtl/nios_mul_seq_combine.sv
// nios_mul_seq_combine
//   Sequencer and combiner around the three-partial-product 16x16 multiply
//   cell. It accepts MUL / MULXUU / MULXSU / MULXSS requests and drives the
//   cell operands and enable. It combines the registered partial products
//   into a 32-bit result that is returned over a valid/ready handshake.
//   The MULX ops use a second cell pass to get a_hi*b_hi, and then apply the
//   signed corrections.
//
//   Optional feature macro: MUL_SEQ_OVERLAP_EN. When it is defined, a new
//   request may be accepted on the same edge as the response handshake.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/ready       request handshake; req_op, req_a, req_b payload
//   cell_src1/src2/en     registered operand/enable drive to the cell
//   cell_p1/p2/p3         partial products (lo*lo, a_lo*b_hi, a_hi*b_lo)
//   rsp_valid/ready       response handshake; rsp_data result word
//
// Parameter
//   CELL_LAT              cell enable-to-product latency; only 1 supported
module nios_mul_seq_combine #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data
);

  if (CELL_LAT != 1) begin : g_bad_cell_lat
    $error("nios_mul_seq_combine: only CELL_LAT == 1 is supported");
  end

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    CAP1  = 3'd2,
    PASS2 = 3'd3,
    CAP2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [31:0] a_lat, b_lat;
  logic [1:0]  op_lat;
  logic [17:0] mid_acc;
  logic [32:0] side_s;

  // p2 + p3 without losing the carry.
  function automatic logic [32:0] side_sum(input logic [31:0] p2, input logic [31:0] p3);
    return {1'b0, p2} + {1'b0, p3};
  endfunction

  // Low result word: p1 + (s << 16), wrapped to 32 bits.
  function automatic logic [31:0] low_word(input logic [31:0] p1, input logic [15:0] s_lo);
    return p1 + {s_lo, 16'h0000};
  endfunction

  // Carry from the low word into the high word: (s + p1[31:16]) >> 16.
  function automatic logic [17:0] mid_carry(input logic [32:0] s, input logic [15:0] p1_hi);
    return 18'(({1'b0, s} + {18'h0, p1_hi}) >> 16);
  endfunction

  // High word: a_hi*b_hi plus the carry, minus the corrections for signed operands.
  function automatic logic [31:0] high_word(input logic [31:0] hh, input logic [17:0] mid,
                                            input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] corr;
    corr = 32'h0;
    if ((op == OP_MULXSU) || (op == OP_MULXSS))
      corr = a[31] ? b : 32'h0;
    if (op == OP_MULXSS)
      corr = corr + (b[31] ? a : 32'h0);
    return hh + {14'h0, mid} - corr;
  endfunction

  always_comb begin
    req_ready = (state == IDLE);
`ifdef MUL_SEQ_OVERLAP_EN
    if ((state == DONE) && rsp_ready)
      req_ready = 1'b1;
`endif
  end

  assign accept = req_valid & req_ready;
  assign side_s = side_sum(cell_p2, cell_p3);

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode; accept in DONE can only occur with the overlap feature
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? PASS1 : IDLE;
      PASS1:   state_nxt = CAP1;
      CAP1:    state_nxt = (op_lat == OP_MUL) ? DONE : PASS2;
      PASS2:   state_nxt = CAP2;
      CAP2:    state_nxt = DONE;
      DONE: begin
        if (rsp_ready)
          state_nxt = accept ? PASS1 : IDLE;
        else
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath; cell_en/rsp_valid are looked ahead from
  // state_nxt so they are high exactly during PASS / DONE cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_en   <= 1'b0;
      cell_src1 <= 32'h0;
      cell_src2 <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      a_lat     <= 32'h0;
      b_lat     <= 32'h0;
      op_lat    <= 2'b00;
      mid_acc   <= 18'h0;
    end else begin
      cell_en   <= (state_nxt == PASS1) || (state_nxt == PASS2);
      rsp_valid <= (state_nxt == DONE);
      if (accept) begin
        a_lat     <= req_a;
        b_lat     <= req_b;
        op_lat    <= req_op;
        cell_src1 <= req_a;
        cell_src2 <= req_b;
      end
      if (state == CAP1) begin
        mid_acc <= mid_carry(side_s, cell_p1[31:16]);
        if (op_lat == OP_MUL) begin
          rsp_data <= low_word(cell_p1, side_s[15:0]);
        end else begin
          cell_src1 <= {16'h0, a_lat[31:16]};
          cell_src2 <= {16'h0, b_lat[31:16]};
        end
      end
      if (state == CAP2)
        rsp_data <= high_word(cell_p1, mid_acc, op_lat, a_lat, b_lat);
    end
  end

endmodule

// File: tb/tb_nios_mul_seq_combine.sv
// Testbench for nios_mul_seq_combine. A cycle-accurate model of the multiply
// cell is connected to the cell ports. Results are compared against a
// reference 64-bit multiply.
module tb_nios_mul_seq_combine;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1 = 32'h0, cell_p2 = 32'h0, cell_p3 = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_pass   = 0;

  nios_mul_seq_combine #(.CELL_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Multiply cell: registered 16x16 unsigned products, gated by enable
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= cell_src1[15:0]  * cell_src2[15:0];
      cell_p2 <= cell_src1[15:0]  * cell_src2[31:16];
      cell_p3 <= cell_src1[31:16] * cell_src2[15:0];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference result: extend the operands according to op, take a 64-bit product
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [65:0] xa, xb, prod;
    xa = ((op == 2'b10) || (op == 2'b11)) ? {{34{a[31]}}, a} : {34'h0, a};
    xb = (op == 2'b11) ? {{34{b[31]}}, b} : {34'h0, b};
    prod = xa * xb;
    return (op == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  // Issue one request at a negedge with the DUT idle. Records the latency
  // (edges, counting the accept edge) and the cell_en pattern. Stalls the
  // consumer for 'stall' cycles, then completes the handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall,
                        output logic [31:0] data, output int lat, output int mask);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    rsp_ready = (stall == 0);
    check_val({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    lat = 0; mask = 0; data = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
      end
      if (cell_en) mask = mask | (1 << k);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      check_val({tag, " timeout"}, 32'd0, 32'd1);
      rsp_ready = 1'b1;
      return;
    end
    data = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val({tag, " hold_vld"}, 32'(rsp_valid), 32'd1);
      check_val({tag, " hold_data"}, rsp_data, data);
      check_val({tag, " hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val({tag, " vld_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] d;
  int lat, mask;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0000FFFF};

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 32'h0; req_b = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst req_ready", 32'(req_ready), 32'd1);
    check_val("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst cell_en", 32'(cell_en), 32'd0);
    check_val("rst rsp_data", rsp_data, 32'h0);
    check_val("rst src1", cell_src1, 32'h0);
    check_val("rst src2", cell_src2, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("mul3x5", 2'b00, 32'd3, 32'd5, 0, d, lat, mask);
    check_val("mul3x5 data", d, 32'h0000000F);
    check_val("mul3x5 lat", 32'(lat), 32'd3);
    check_val("mul3x5 en", 32'(mask), 32'b10);

    run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, d, lat, mask);
    check_val("mul_ff data", d, 32'h00000001);

    run_op("xuu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, d, lat, mask);
    check_val("xuu_ff data", d, 32'hFFFFFFFE);
    check_val("xuu_ff lat", 32'(lat), 32'd5);
    check_val("xuu_ff en", 32'(mask), 32'b1010);

    run_op("xss_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, d, lat, mask);
    check_val("xss_ff data", d, 32'h00000000);
    run_op("xss_min", 2'b11, 32'h80000000, 32'h80000000, 0, d, lat, mask);
    check_val("xss_min data", d, 32'h40000000);
    run_op("xsu_m1x2", 2'b10, 32'hFFFFFFFF, 32'd2, 0, d, lat, mask);
    check_val("xsu_m1x2 data", d, 32'hFFFFFFFF);

    // Backpressure: consumer stalls for 10 cycles
    run_op("bp", 2'b00, 32'h00012345, 32'h00010000, 10, d, lat, mask);
    check_val("bp data", d, 32'h23450000);
    @(negedge clk);
    check_val("bp single hs", 32'(rsp_valid), 32'd0);

    // Reset during PASS2 of a MULXUU
    req_op = 2'b01; req_a = 32'hDEADBEEF; req_b = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    check_val("rstp2 in_pass2", 32'(cell_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstp2 rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rstp2 req_ready", 32'(req_ready), 32'd1);
    check_val("rstp2 cell_en", 32'(cell_en), 32'd0);
    check_val("rstp2 src1", cell_src1, 32'h0);
    check_val("rstp2 src2", cell_src2, 32'h0);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd5; req_b = 32'd5;
    @(negedge clk);
    check_val("rst_req ignored", 32'(cell_en), 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_valid || cell_en) seen++;
      end
      check_val("rstp2 no rsp", 32'(seen), 32'd0);
    end
    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 0, d, lat, mask);
    check_val("mul7x6 data", d, 32'h0000002A);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          stall;
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      stall = $urandom_range(0, 2);
      run_op("rnd", op, a, b, stall, d, lat, mask);
      check_val($sformatf("rnd%0d data", i), d, ref_mul(op, a, b));
      check_val($sformatf("rnd%0d lat", i), 32'(lat), (op == 2'b00) ? 32'd3 : 32'd5);
      check_val($sformatf("rnd%0d en", i), 32'(mask), (op == 2'b00) ? 32'b10 : 32'b1010);
    end

    // Stream of four MULs with req_valid held high and the consumer always ready
    begin
      int acc_cyc [$];
      logic [31:0] got [$];
      int cyc, idx, exp_gap;
      bit pending;
      cyc = 0; idx = 0; pending = 1'b0;
`ifdef MUL_SEQ_OVERLAP_EN
      exp_gap = 3;
`else
      exp_gap = 4;
`endif
      rsp_ready = 1'b1; req_op = 2'b00; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
      while (((got.size() < 4) || (idx < 4)) && (cyc < 80)) begin
        if (cyc > 0) @(negedge clk);
        cyc++;
        if (pending) begin
          pending = 1'b0;
          idx++;
          if (idx < 4) begin
            req_a = 32'(idx + 1); req_b = 32'(idx + 1);
          end else begin
            req_valid = 1'b0;
          end
        end
        if (rsp_valid) got.push_back(rsp_data);
        if (req_valid && req_ready) begin
          acc_cyc.push_back(cyc);
          pending = 1'b1;
        end
      end
      check_val("stream rsp count", 32'(got.size()), 32'd4);
      check_val("stream acc count", 32'(acc_cyc.size()), 32'd4);
      for (int i = 0; i < got.size() && i < 4; i++)
        check_val($sformatf("stream rsp%0d", i), got[i], ref_mul(2'b00, 32'(i + 1), 32'(i + 1)));
      for (int i = 1; i < acc_cyc.size(); i++)
        check_val($sformatf("stream gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(exp_gap));
      @(negedge clk);
      @(negedge clk);
      check_val("stream idle", 32'(rsp_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
